regfile_write_scheduler: RTL and testbench

- Owns the single write port of the team's parameterised register file.
- Clears every register through that port after reset, or on command, by sweeping zeros into each register.
- Then shares the port between two writeback requesters (e.g. ALU and load path) using valid/ready handshakes and round-robin arbitration.
- Sits between the writeback stages and the register file's WriteData/WriteSelect/WriteEnable inputs.

---
 rtl/regfile_write_scheduler.sv | 135 +++++++++++++
 tb/tb_regfile_write_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// Single write-port owner for the register file: zero-fills every register after reset/Clear,
// then round-robin arbitrates two writeback requesters onto the port with a registered output.
module regfile_write_scheduler #(
   parameter int REG_SELECT_WIDTH   = 5,
   parameter int DATA_WIDTH         = 32,
   parameter int ZERO_REG_HARDWIRED = 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        Clear,
   input  logic                        Req0Valid,
   input  logic [REG_SELECT_WIDTH-1:0] Req0Select,
   input  logic [DATA_WIDTH-1:0]       Req0Data,
   output logic                        Req0Ready,
   input  logic                        Req1Valid,
   input  logic [REG_SELECT_WIDTH-1:0] Req1Select,
   input  logic [DATA_WIDTH-1:0]       Req1Data,
   output logic                        Req1Ready,
   output logic [DATA_WIDTH-1:0]       WriteData,
   output logic [REG_SELECT_WIDTH-1:0] WriteSelect,
   output logic                        WriteEnable,
   output logic                        InitBusy,
   output logic                        DebugStateArb
);

   // Handshake: a write is accepted in any cycle where ReqNValid && ReqNReady; Ready is only
   // raised for the requester actually granted, so at most one Ready is high per cycle.

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_ARB  = 1'b1
   } state_t;

   localparam logic [REG_SELECT_WIDTH-1:0] LAST_SEL = '1;

   state_t                        state_q, state_d;
   logic [REG_SELECT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                          ptr_q, ptr_d;
   logic                          we_q, we_d;
   logic [REG_SELECT_WIDTH-1:0]   wsel_q, wsel_d;
   logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
   logic                          busy_q, busy_d;

   logic                          arb_open;
   logic                          grant0;
   logic                          grant1;
   logic [REG_SELECT_WIDTH-1:0]   gsel;
   logic [DATA_WIDTH-1:0]         gdata;
   logic                          gsel_is_zero;

   // ptr_q == 0 favours requester 0 when both are valid.
   always_comb begin
      arb_open     = (state_q == ST_ARB) && !Clear && !Reset;
      grant0       = arb_open && Req0Valid && (!Req1Valid || !ptr_q);
      grant1       = arb_open && Req1Valid && !grant0;
      gsel         = grant1 ? Req1Select : Req0Select;
      gdata        = grant1 ? Req1Data   : Req0Data;
      gsel_is_zero = (gsel == '0);
   end

   assign Req0Ready = grant0;
   assign Req1Ready = grant1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      wsel_d  = wsel_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;

      if (Clear) begin
         state_d = ST_INIT;
         cnt_d   = '0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               we_d    = 1'b1;
               wsel_d  = cnt_q;
               wdata_d = '0;
               if (cnt_q == LAST_SEL) begin
                  state_d = ST_ARB;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_ARB: begin
               if (grant0 || grant1) begin
                  wsel_d  = gsel;
                  wdata_d = gdata;
                  // Writes to a hardwired zero register are consumed but never reach the file.
                  we_d    = !((ZERO_REG_HARDWIRED != 0) && gsel_is_zero);
                  ptr_d   = grant0;
               end
            end
            default: begin
               state_d = ST_INIT;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         we_q    <= 1'b0;
         wsel_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         we_q    <= we_d;
         wsel_q  <= wsel_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   assign WriteEnable   = we_q;
   assign WriteSelect   = wsel_q;
   assign WriteData     = wdata_q;
   assign InitBusy      = busy_q;
   assign DebugStateArb = (state_q == ST_ARB);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: two instances (zero register hardwired / not) share stimulus;
// a behavioural model predicts Ready/InitBusy and the ordered stream of register-file writes.
module tb_regfile_write_scheduler;

  localparam int SW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 1 << SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [SW-1:0] s0 = '0, s1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          r0_a, r1_a, we_a, busy_a, dbg_a;
  logic [SW-1:0] wsel_a;
  logic [DW-1:0] wdata_a;
  logic          r0_b, r1_b, we_b, busy_b, dbg_b;
  logic [SW-1:0] wsel_b;
  logic [DW-1:0] wdata_b;

  regfile_write_scheduler #(.REG_SELECT_WIDTH(SW), .DATA_WIDTH(DW), .ZERO_REG_HARDWIRED(1)) u_dut_hw (
    .Clk(clk), .Reset(reset), .Clear(clear),
    .Req0Valid(v0), .Req0Select(s0), .Req0Data(d0), .Req0Ready(r0_a),
    .Req1Valid(v1), .Req1Select(s1), .Req1Data(d1), .Req1Ready(r1_a),
    .WriteData(wdata_a), .WriteSelect(wsel_a), .WriteEnable(we_a),
    .InitBusy(busy_a), .DebugStateArb(dbg_a)
  );

  regfile_write_scheduler #(.REG_SELECT_WIDTH(SW), .DATA_WIDTH(DW), .ZERO_REG_HARDWIRED(0)) u_dut_nohw (
    .Clk(clk), .Reset(reset), .Clear(clear),
    .Req0Valid(v0), .Req0Select(s0), .Req0Data(d0), .Req0Ready(r0_b),
    .Req1Valid(v1), .Req1Select(s1), .Req1Data(d1), .Req1Ready(r1_b),
    .WriteData(wdata_b), .WriteSelect(wsel_b), .WriteEnable(we_b),
    .InitBusy(busy_b), .DebugStateArb(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  logic [SW+DW-1:0] exp_qa[$];
  logic [SW+DW-1:0] exp_qb[$];
  int               due_qa[$];
  int               due_qb[$];
  int               checks = 0;
  int               errors = 0;
  int               cycle  = 0;
  bit               mon_on = 1'b0;
  bit               model_on = 1'b0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (reset) mon_on <= 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: either sweeping (next register to zero) or arbitrating with a favoured requester.
  bit m_init  = 1'b1;
  int m_sweep = 0;
  int m_fav   = 0;

  always @(negedge clk) begin
    bit g0, g1;
    logic [SW+DW-1:0] wr;
    g0 = 1'b0;
    g1 = 1'b0;
    if (model_on && !reset && !clear && !m_init) begin
      if (v0 && v1) begin
        g0 = (m_fav == 0);
        g1 = (m_fav == 1);
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    if (model_on) begin
      check("ready0_hw",   64'(r0_a),   64'(g0));
      check("ready1_hw",   64'(r1_a),   64'(g1));
      check("ready0_nohw", 64'(r0_b),   64'(g0));
      check("ready1_nohw", 64'(r1_b),   64'(g1));
      check("busy_hw",     64'(busy_a), 64'(m_init));
      check("busy_nohw",   64'(busy_b), 64'(m_init));
    end
    if (reset) begin
      m_init   = 1'b1;
      m_sweep  = 0;
      m_fav    = 0;
      model_on = 1'b1;
    end else if (!model_on) begin
      m_init = 1'b1;
    end else if (clear) begin
      m_init  = 1'b1;
      m_sweep = 0;
    end else if (m_init) begin
      wr = {SW'(m_sweep), {DW{1'b0}}};
      exp_qa.push_back(wr); due_qa.push_back(cycle + 1);
      exp_qb.push_back(wr); due_qb.push_back(cycle + 1);
      m_sweep++;
      if (m_sweep == NREG) m_init = 1'b0;
    end else if (g0 || g1) begin
      wr = g0 ? {s0, d0} : {s1, d1};
      exp_qb.push_back(wr); due_qb.push_back(cycle + 1);
      if (wr[SW+DW-1:DW] != '0) begin
        exp_qa.push_back(wr); due_qa.push_back(cycle + 1);
      end
      m_fav = g0 ? 1 : 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit due_a, due_b;
    if (mon_on) begin
      due_a = (due_qa.size() > 0) && (due_qa[0] == cycle);
      due_b = (due_qb.size() > 0) && (due_qb[0] == cycle);
      check("we_hw", 64'(we_a), 64'(due_a));
      if (we_a && due_a) check("write_hw", 64'({wsel_a, wdata_a}), 64'(exp_qa[0]));
      if (due_a) begin
        void'(exp_qa.pop_front());
        void'(due_qa.pop_front());
      end
      check("we_nohw", 64'(we_b), 64'(due_b));
      if (we_b && due_b) check("write_nohw", 64'({wsel_b, wdata_b}), 64'(exp_qb[0]));
      if (due_b) begin
        void'(exp_qb.pop_front());
        void'(due_qb.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic va, input logic [SW-1:0] sa, input logic [DW-1:0] da,
                         input logic vb, input logic [SW-1:0] sb, input logic [DW-1:0] db);
    v0 = va; s0 = sa; d0 = da;
    v1 = vb; s1 = sb; d1 = db;
  endtask

  initial begin
    // Reset sweep with requester 0 already waiting.
    set_req(1'b1, 5'd5, 32'hCAFE0001, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(34);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(2);

    // Single requester.
    set_req(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    step(1);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(2);

    // Contention for four cycles.
    set_req(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    step(4);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(2);

    // Write to register 0 from requester 1.
    set_req(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    step(1);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(2);

    // Clear mid-traffic, then a second Clear partway through the sweep.
    set_req(1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 32'h0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(11);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(34);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(2);

    // Reset part-way through a sweep.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(21);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(34);

    // Randomised traffic with occasional Clear and Reset.
    for (int i = 0; i < 600; i++) begin
      set_req(1'($urandom_range(0, 1)), SW'($urandom_range(0, NREG - 1)), $urandom(),
              1'($urandom_range(0, 1)), SW'($urandom_range(0, NREG - 1)), $urandom());
      if ($urandom_range(0, 9) == 0) s1 = '0;
      clear = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step(1);
    end
    clear = 1'b0;
    reset = 1'b0;
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(40);

    check("pending_hw",   64'(exp_qa.size()), 64'd0);
    check("pending_nohw", 64'(exp_qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
